// File: rtl/truth_table_sequencer.sv
// truth_table_sequencer
//   Sweep engine for a 4-input combinational function unit. It drives all 16
//   input vectors in order, holds each one for SETTLE+1 cycles and samples f at
//   the last edge of that window. The samples build a 16-bit truth table, and a
//   running minterm count is kept alongside.
//
// Ports
//   clk         system clock, rising-edge active
//   rst         synchronous active-high reset, priority over all inputs
//   start       sweep request, sampled only while idle
//   f           function-unit output (combinational from x1..x4)
//   x1..x4      function-unit inputs, {x1,x2,x3,x4} = vector index while running
//   busy        high while the sweep is running
//   done        one-cycle completion pulse
//   tt          captured truth table, tt[i] = f for vector i
//   ones_count  population count of tt (0..16)
module truth_table_sequencer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f,
    output logic        x1,
    output logic        x2,
    output logic        x3,
    output logic        x4,
    output logic        busy,
    output logic        done,
    output logic [15:0] tt,
    output logic [4:0]  ones_count
);

    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TT_W   = 16;
    localparam int unsigned ONES_W = 5;

    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TT_W - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [TT_W-1:0]   tt_q,    tt_d;
    logic [ONES_W-1:0] ones_q,  ones_d;

    // Output registers are loaded from next-state values, so they line up
    // cycle-for-cycle with the state they decode.
    logic [IDX_W-1:0]  x_q,     x_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        x_d     = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Previous results hold until a new sweep is accepted.
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                end
            end

            ST_RUN: begin
                if (cnt_q == SETTLE_C) begin
                    // Last edge of this vector's window: capture f.
                    tt_d[idx_q] = f;
                    ones_d      = ones_q + ONES_W'(f);
                    cnt_d       = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
        x_d    = busy_d ? idx_d : '0;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
            x_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
            x_q     <= x_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x1         = x_q[3];
    assign x2         = x_q[2];
    assign x3         = x_q[1];
    assign x4         = x_q[0];
    assign busy       = busy_q;
    assign done       = done_q;
    assign tt         = tt_q;
    assign ones_count = ones_q;

endmodule
